// File: rtl/sd2_ramp_dac.sv
`timescale 1ns/1ps
// Second-order delta-sigma DAC for the 8-bit audio mix, with a soft-mute gain ramp.
// One clock from an enabled edge to o_do. i_ce=0 freezes every register.
module sd2_ramp_dac #(
  parameter int DW       = 8,
  parameter int IW       = 12,
  parameter int RAMP_DIV = 64
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [DW-1:0] i_di,
  input  logic          i_mute,
  output logic          o_do,
  output logic          o_ramping,
  output logic [7:0]    o_gain
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int SW = IW + 2;
  localparam logic [CW-1:0]        CNT_LAST = CW'(RAMP_DIV - 1);
  localparam logic signed [SW-1:0] SAT_MAX  = SW'(2**(IW-1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN  = -SAT_MAX;
  localparam logic signed [SW-1:0] FB_MAG   = SW'(2**(DW-1));

  typedef enum logic [1:0] {
    ST_MUTED     = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_gain;
  logic [7:0]            w_gain_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_step;

  logic signed [IW-1:0]  r_int1;
  logic signed [IW-1:0]  r_int2;
  logic                  r_do;
  logic signed [DW-1:0]  w_s;
  logic signed [DW+8:0]  w_prod;
  logic signed [SW-1:0]  w_x;
  logic signed [SW-1:0]  w_fb;
  logic signed [SW-1:0]  w_sum1;
  logic signed [SW-1:0]  w_sum2;
  logic signed [IW-1:0]  w_int1_nxt;
  logic signed [IW-1:0]  w_int2_nxt;

  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)
      return IW'(SAT_MAX);
    else if (v < SAT_MIN)
      return IW'(SAT_MIN);
    else
      return IW'(v);
  endfunction

  // Offset-binary to two's complement; the >>>9 keeps |x| at half of the feedback step.
  assign w_s        = {~i_di[DW-1], i_di[DW-2:0]};
  assign w_prod     = w_s * $signed({1'b0, r_gain});
  assign w_x        = SW'(w_prod >>> 9);
  assign w_fb       = r_do ? FB_MAG : -FB_MAG;
  assign w_sum1     = SW'(r_int1) + w_x - w_fb;
  assign w_int1_nxt = sat(w_sum1);
  assign w_sum2     = SW'(r_int2) + SW'(w_int1_nxt) - w_fb;
  assign w_int2_nxt = sat(w_sum2);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_int1 <= '0;
      r_int2 <= '0;
      r_do   <= 1'b0;
    end else if (i_ce) begin
      r_int1 <= w_int1_nxt;
      r_int2 <= w_int2_nxt;
      r_do   <= ~w_int2_nxt[IW-1];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_MUTED;
      r_gain  <= 8'd0;
      r_cnt   <= '0;
    end else if (i_ce) begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_step    = (r_cnt == CNT_LAST);
  assign w_cnt_inc = w_step ? '0 : r_cnt + CW'(1);

  // Reversing direction mid-ramp keeps gain and counter so the fade stays continuous.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_MUTED: begin
        if (!i_mute) begin
          w_state_nxt = ST_RAMP_UP;
          w_cnt_nxt   = '0;
        end
      end
      ST_RAMP_UP: begin
        if (i_mute) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_step) begin
            w_gain_nxt = r_gain + 8'd1;
            if (r_gain == 8'd254)
              w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (i_mute)
          w_state_nxt = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (!i_mute) begin
          w_state_nxt = ST_RAMP_UP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_step) begin
            w_gain_nxt = r_gain - 8'd1;
            if (r_gain == 8'd1)
              w_state_nxt = ST_MUTED;
          end
        end
      end
      default: w_state_nxt = ST_MUTED;
    endcase
  end

  always_comb begin
    o_ramping = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
  end

  assign o_do   = r_do;
  assign o_gain = r_gain;

endmodule

// File: tb/tb_sd2_ramp_dac.sv
`timescale 1ns/1ps
// Directed bench for sd2_ramp_dac with a fast ramp (RAMP_DIV=4).
module tb_sd2_ramp_dac;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] di;
  logic       mute;
  logic       dout;
  logic       ramping;
  logic [7:0] gain;

  int n_checks = 0;
  int n_fail   = 0;

  sd2_ramp_dac #(.DW(8), .IW(12), .RAMP_DIV(4)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_ce      (ce),
    .i_di      (di),
    .i_mute    (mute),
    .o_do      (dout),
    .o_ramping (ramping),
    .o_gain    (gain)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ce;
    logic       mute;
    logic [7:0] di;
    logic       exp_do;
    logic [7:0] exp_gain;
    logic       exp_ramp;
  } vec_t;

  vec_t vt[14];

  int  m_i1, m_i2, m_gain, m_cnt, m_st;
  bit  m_do;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b1; mute = 1'b1; di = 8'h80;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int clamp(input int v);
    if (v > 2047) return 2047;
    if (v < -2047) return -2047;
    return v;
  endfunction

  task automatic m_reset();
    m_i1 = 0; m_i2 = 0; m_do = 1'b0; m_gain = 0; m_cnt = 0; m_st = 0;
  endtask

  // Reference: one enabled edge of the modulator and ramp (states 0 muted,1 up,2 run,3 down).
  task automatic m_step(input int d, input bit mu);
    int s, x, fb;
    s  = d - 128;
    x  = (s * m_gain) >>> 9;
    fb = m_do ? 128 : -128;
    m_i1 = clamp(m_i1 + x - fb);
    m_i2 = clamp(m_i2 + m_i1 - fb);
    m_do = (m_i2 >= 0);
    case (m_st)
      0: if (!mu) begin m_st = 1; m_cnt = 0; end
      1: begin
        if (mu) m_st = 3;
        else if (m_cnt == 3) begin
          m_cnt = 0; m_gain++;
          if (m_gain == 255) m_st = 2;
        end else m_cnt++;
      end
      2: if (mu) m_st = 3;
      default: begin
        if (!mu) m_st = 1;
        else if (m_cnt == 3) begin
          m_cnt = 0; m_gain--;
          if (m_gain == 0) m_st = 0;
        end else m_cnt++;
      end
    endcase
  endtask

  initial begin
    int ones, bad, n, maxabs, a1, a2, hold_bad, model_bad;
    logic prev_do;
    logic [7:0] prev_gain;

    rst = 1'b1; ce = 1'b1; mute = 1'b1; di = 8'h80;

    // Idle tone with gain held at zero
    do_reset();
    check("reset_do", int'(dout), 0);
    check("reset_gain", int'(gain), 0);
    check("reset_ramping", int'(ramping), 0);
    check("reset_int1", int'(dut.r_int1), 0);
    ones = 0; bad = 0;
    for (int i = 0; i < 2048; i++) begin
      tick();
      ones += int'(dout);
      if (gain != 8'd0 || ramping) bad++;
    end
    check("idle_gain_ramping_bad", bad, 0);
    check_range("idle_ones", ones, 1016, 1032);

    vt[0]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 8'h37, 1'b1, 8'd0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 8'h80, 1'b0, 8'd0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 8'h80, 1'b1, 8'd0, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 8'h80, 1'b0, 8'd0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 8'h80, 1'b0, 8'd1, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 8'h80, 1'b0, 8'd1, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 8'h80, 1'b1, 8'd1, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'd1, 1'b1};
    vt[10] = '{1'b1, 1'b1, 8'h80, 1'b0, 8'd1, 1'b1};
    vt[11] = '{1'b1, 1'b1, 8'h80, 1'b0, 8'd1, 1'b1};
    vt[12] = '{1'b1, 1'b1, 8'h80, 1'b1, 8'd0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 8'h80, 1'b1, 8'd0, 1'b0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      ce = vt[i].ce; mute = vt[i].mute; di = vt[i].di;
      tick();
      check($sformatf("vec%0d_{do,gain,ramp}", i),
            int'({dout, gain, ramping}),
            int'({vt[i].exp_do, vt[i].exp_gain, vt[i].exp_ramp}));
    end

    // Full ramp up: 255 steps of 4 ticks after the start edge
    do_reset();
    ce = 1'b1; mute = 1'b1; di = 8'h80;
    tick();
    mute = 1'b0;
    tick();
    check("up_start_ramping", int'(ramping), 1);
    n = 0;
    while (ramping && n < 2000) begin
      tick();
      n++;
    end
    check("up_ticks", n, 1020);
    check("up_gain", int'(gain), 255);
    check("up_state_run", int'(dut.r_state), 2);

    // Output density in RUN
    di = 8'hFF; ones = 0; maxabs = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      ones += int'(dout);
      a1 = int'(dut.r_int1); a2 = int'(dut.r_int2);
      if (a1 < 0) a1 = -a1;
      if (a2 < 0) a2 = -a2;
      if (a1 > maxabs) maxabs = a1;
      if (a2 > maxabs) maxabs = a2;
    end
    check_range("run_ff_ones", ones, 3015, 3097);
    di = 8'h00; ones = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      ones += int'(dout);
      a1 = int'(dut.r_int1); a2 = int'(dut.r_int2);
      if (a1 < 0) a1 = -a1;
      if (a2 < 0) a2 = -a2;
      if (a1 > maxabs) maxabs = a1;
      if (a2 > maxabs) maxabs = a2;
    end
    check_range("run_00_ones", ones, 999, 1081);
    check_range("run_int_peak", maxabs, 0, 2047);
    check("run_gain_held", int'(gain), 255);

    // Reverse mid-ramp at gain 100
    do_reset();
    ce = 1'b1; mute = 1'b0; di = 8'h80;
    n = 0;
    while (gain != 8'd100 && n < 2000) begin
      tick();
      n++;
    end
    check("down_reach_100", int'(gain), 100);
    mute = 1'b1;
    n = 0;
    while (ramping && n < 1000) begin
      tick();
      n++;
    end
    check_range("down_ticks", n, 397, 403);
    check("down_gain", int'(gain), 0);
    check("down_state_muted", int'(dut.r_state), 0);

    // Sparse clock enable against the per-tick reference
    do_reset();
    m_reset();
    di = 8'hC0; mute = 1'b0;
    hold_bad = 0; model_bad = 0;
    for (int k = 0; k < 3000; k++) begin
      ce = (k % 3 == 0);
      if (k == 2400) mute = 1'b1;
      prev_do = dout; prev_gain = gain;
      tick();
      if (ce) begin
        m_step(int'(di), mute);
        if (dout !== m_do || int'(gain) != m_gain ||
            ramping !== (m_st == 1 || m_st == 3))
          model_bad++;
      end else if (dout !== prev_do || gain !== prev_gain) begin
        hold_bad++;
      end
    end
    check("ce_model_mismatches", model_bad, 0);
    check("ce_hold_violations", hold_bad, 0);

    // Reset during ramp up
    do_reset();
    ce = 1'b1; mute = 1'b0; di = 8'hC0;
    n = 0;
    while (gain != 8'd37 && n < 2000) begin
      tick();
      n++;
    end
    check("rst_reach_37", int'(gain), 37);
    rst = 1'b1;
    tick();
    check("rst_gain", int'(gain), 0);
    check("rst_do", int'(dout), 0);
    check("rst_ramping", int'(ramping), 0);
    check("rst_state", int'(dut.r_state), 0);
    check("rst_int1", int'(dut.r_int1), 0);
    check("rst_int2", int'(dut.r_int2), 0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
